// File: rtl/boot_loader.sv
// Serial boot loader: receives an A5/LEN_H/LEN_L/payload/CSUM frame on an 8N1 UART line and writes it to program memory.
// Define LOADER_TIMEOUT_EN to abort a frame when the gap between bytes exceeds TIMEOUT_BITS bit times.
module boot_loader #(
  parameter int          CLKS_PER_BIT = 234,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] MAX_LEN      = 16'h0800,
  parameter int          TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_LEN_H = 3'd1;
  localparam logic [2:0] S_LEN_L = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic rxMeta_q, rxSync_q, rxPrev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  logic          rxBusy_q, rxBusy_d;
  logic [3:0]    rxBit_q, rxBit_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic          byteValid_q, byteValid_d;
  logic          frameErr_q, frameErr_d;

  // rxBit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_comb begin
    rxBusy_d    = rxBusy_q;
    rxBit_d     = rxBit_q;
    rxCnt_d     = rxCnt_q;
    rxShift_d   = rxShift_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    if (!rxBusy_q) begin
      if (rxPrev_q && !rxSync_q) begin
        rxBusy_d = 1'b1;
        rxBit_d  = 4'd0;
        rxCnt_d  = '0;
      end
    end else if (rxCnt_q == ((rxBit_q == 4'd0) ? HALF_M1 : FULL_M1)) begin
      rxCnt_d = '0;
      rxBit_d = rxBit_q + 4'd1;
      if (rxBit_q == 4'd0) begin
        if (rxSync_q) rxBusy_d = 1'b0;
      end else if (rxBit_q <= 4'd8) begin
        rxShift_d = {rxSync_q, rxShift_q[7:1]};
      end else begin
        rxBusy_d    = 1'b0;
        byteValid_d = rxSync_q;
        frameErr_d  = !rxSync_q;
      end
    end else begin
      rxCnt_d = rxCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxBusy_q    <= 1'b0;
      rxBit_q     <= 4'd0;
      rxCnt_q     <= '0;
      rxShift_q   <= 8'h00;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxBusy_q    <= rxBusy_d;
      rxBit_q     <= rxBit_d;
      rxCnt_q     <= rxCnt_d;
      rxShift_q   <= rxShift_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  logic [2:0]  state_q, state_d;
  logic [7:0]  lenH_q, lenH_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] memAddr_q, memAddr_d;
  logic [7:0]  memWdata_q, memWdata_d;
  logic        memWe_q, memWe_d;
  logic        cpuHold_q, cpuHold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] toCnt_q, toCnt_d;
  logic        toActive;

  assign toActive = (state_q != S_SYNC) && (state_q != S_RUN);
  assign timeout  = toActive && !byteValid_q && (toCnt_q == TO_LAST);

  always_comb begin
    toCnt_d = toCnt_q + 32'd1;
    if (!toActive || byteValid_q || timeout) toCnt_d = 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) toCnt_q <= 32'd0;
    else      toCnt_q <= toCnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  logic [15:0] lenFull;
  logic [7:0]  csumTotal;
  assign lenFull   = {lenH_q, rxShift_q};
  assign csumTotal = sum_q + rxShift_q;

  // A framing error aborts from any state; otherwise the FSM only moves on a received byte
  always_comb begin
    state_d    = state_q;
    lenH_d     = lenH_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = 1'b0;
    cpuHold_d  = cpuHold_q;
    done_d     = done_q;
    err_d      = err_q;
    if (frameErr_q) begin
      err_d   = 1'b1;
      state_d = S_SYNC;
    end else if (byteValid_q) begin
      case (state_q)
        S_SYNC, S_RUN: begin
          if (rxShift_q == 8'hA5) begin
            err_d     = 1'b0;
            cpuHold_d = 1'b1;
            done_d    = 1'b0;
            state_d   = S_LEN_H;
          end
        end
        S_LEN_H: begin
          lenH_d  = rxShift_q;
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          if (lenFull == 16'd0 || lenFull > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            len_d   = lenFull;
            idx_d   = 16'd0;
            sum_d   = 8'h00;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          memWe_d    = 1'b1;
          memAddr_d  = BASE_ADDR + idx_q;
          memWdata_d = rxShift_q;
          sum_d      = sum_q + rxShift_q;
          idx_d      = idx_q + 16'd1;
          if (idx_q + 16'd1 == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (csumTotal == 8'h00) begin
            done_d    = 1'b1;
            cpuHold_d = 1'b0;
            state_d   = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = S_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_SYNC;
      lenH_q     <= 8'h00;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      sum_q      <= 8'h00;
      memAddr_q  <= 16'h0000;
      memWdata_q <= 8'h00;
      memWe_q    <= 1'b0;
      cpuHold_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lenH_q     <= lenH_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      cpuHold_q  <= cpuHold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_we    = memWe_q;
  assign cpu_hold  = cpuHold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (base 0x0000 and 0xFFFF) share one UART line; expected memory writes
// are queued per instance as bytes are sent and popped by a monitor whenever mem_we is seen.
module tb_boot_loader;

  localparam int CPB    = 8;
  localparam int A_BASE = 16'h0000;
  localparam int B_BASE = 16'hFFFF;
  localparam int MAXL   = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  logic [15:0] addrA, addrB;
  logic [7:0]  wdA, wdB;
  logic        weA, weB, holdA, holdB, doneA, doneB, errA, errB;

  int total = 0;
  int bad   = 0;

  logic [23:0] qA[$];
  logic [23:0] qB[$];
  logic [7:0]  pay[$];
  bit          expDone, expErr, expHold;

  always #5 clk = ~clk;

  boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000), .MAX_LEN(16'h0800)) dutA (
    .clk(clk), .rst(rst), .rx(rx),
    .mem_addr(addrA), .mem_wdata(wdA), .mem_we(weA),
    .cpu_hold(holdA), .done(doneA), .err(errA)
  );

  boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF), .MAX_LEN(16'h0800)) dutB (
    .clk(clk), .rst(rst), .rx(rx),
    .mem_addr(addrB), .mem_wdata(wdB), .mem_we(weB),
    .cpu_hold(holdB), .done(doneB), .err(errB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    logic [23:0] e;
    if (weA === 1'b1) begin
      if (qA.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL writeA: got %h@%h, wanted no write", wdA, addrA);
      end else begin
        e = qA.pop_front();
        checkOutput("writeA", {8'h00, addrA, wdA}, {8'h00, e});
      end
    end
    if (weB === 1'b1) begin
      if (qB.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL writeB: got %h@%h, wanted no write", wdB, addrB);
      end else begin
        e = qB.pop_front();
        checkOutput("writeB", {8'h00, addrB, wdB}, {8'h00, e});
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit badStop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = badStop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pushWrite(input int i, input logic [7:0] d);
    qA.push_back({16'((A_BASE + i) % 65536), d});
    qB.push_back({16'((B_BASE + i) % 65536), d});
  endtask

  // Length bytes, payload from pay[] and checksum; the model decides the frame outcome from the sums
  task automatic sendBody(input logic [15:0] len, input logic [7:0] csum);
    int s;
    s = 0;
    sendByte(len[15:8], 1'b0);
    sendByte(len[7:0], 1'b0);
    if (len == 16'd0 || int'(len) > MAXL) begin
      expErr = 1'b1;
      return;
    end
    for (int i = 0; i < pay.size(); i++) begin
      pushWrite(i, pay[i]);
      s += int'(pay[i]);
      sendByte(pay[i], 1'b0);
    end
    sendByte(csum, 1'b0);
    if ((s + int'(csum)) % 256 == 0) begin
      expDone = 1'b1;
      expHold = 1'b0;
    end else begin
      expErr = 1'b1;
    end
  endtask

  task automatic sendSync();
    sendByte(8'hA5, 1'b0);
    expErr  = 1'b0;
    expHold = 1'b1;
    expDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] len, input logic [7:0] csum);
    sendSync();
    sendBody(len, csum);
  endtask

  task automatic checkStatus(input string name);
    repeat (4) @(negedge clk);
    checkOutput({name, ".doneA"}, 32'(doneA), 32'(expDone));
    checkOutput({name, ".errA"},  32'(errA),  32'(expErr));
    checkOutput({name, ".holdA"}, 32'(holdA), 32'(expHold));
    checkOutput({name, ".doneB"}, 32'(doneB), 32'(expDone));
    checkOutput({name, ".errB"},  32'(errB),  32'(expErr));
    checkOutput({name, ".holdB"}, 32'(holdB), 32'(expHold));
    checkOutput({name, ".pendA"}, 32'(qA.size()), 32'd0);
    checkOutput({name, ".pendB"}, 32'(qB.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, ".addr"},  32'(addrA), 32'h0);
    checkOutput({name, ".wdata"}, 32'(wdA),   32'h0);
    checkOutput({name, ".we"},    32'(weA),   32'h0);
    checkOutput({name, ".hold"},  32'(holdA), 32'h1);
    checkOutput({name, ".done"},  32'(doneA), 32'h0);
    checkOutput({name, ".err"},   32'(errA),  32'h0);
    checkOutput({name, ".weB"},   32'(weB),   32'h0);
  endtask

  initial begin
    int          len;
    int          s;
    logic [7:0]  b;
    logic [7:0]  csum;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    expDone = 1'b0; expErr = 1'b0; expHold = 1'b1;
    repeat (4) @(negedge clk);

    pay = '{8'h11, 8'h22, 8'h33};
    applyStimulus(16'd3, 8'h9A);
    checkStatus("basic");

    // 0.3-bit glitch on an idle line must not produce a byte
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkStatus("glitch");

    sendSync();
    checkStatus("reloadSync");
    pay = '{8'h10, 8'h20};
    sendBody(16'd2, 8'h00);
    checkStatus("badCsum");

    pay.delete();
    applyStimulus(16'h0000, 8'h00);
    checkStatus("lenZero");
    applyStimulus(16'h0801, 8'h00);
    checkStatus("lenOver");

    pay = '{8'hAA, 8'h55};
    applyStimulus(16'd2, 8'h01);
    checkStatus("wrap");

    sendSync();
    sendByte(8'h00, 1'b0);
    sendByte(8'h03, 1'b0);
    pushWrite(0, 8'h11);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b1);
    expErr = 1'b1;
    checkStatus("framing");

    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(1, 5);
      s = 0;
      pay.delete();
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        pay.push_back(b);
        s += int'(b);
      end
      csum = 8'((256 - (s % 256)) % 256);
      if ($urandom_range(0, 3) == 0) csum = csum + 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        sendByte(b, 1'b0);
      end
      repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
      applyStimulus(16'(len), csum);
      checkStatus("random");
    end

`ifdef LOADER_TIMEOUT_EN
    sendSync();
    sendByte(8'h00, 1'b0);
    sendByte(8'h02, 1'b0);
    repeat (41 * CPB + 10) @(negedge clk);
    expErr = 1'b1;
    checkStatus("timeout");
`endif

    // Largest legal length is accepted; reset then lands in the middle of the payload
    sendSync();
    sendByte(8'h08, 1'b0);
    sendByte(8'h00, 1'b0);
    pushWrite(0, 8'h11);
    sendByte(8'h11, 1'b0);
    checkStatus("maxLen");
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetOutputs("midReset");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    expDone = 1'b0; expErr = 1'b0; expHold = 1'b1;
    sendByte(8'h22, 1'b0);
    checkStatus("afterReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Serial program loader upstream of the cpu top's memory.
- Receives a framed program image over a UART line (8N1) and writes it byte-by-byte into program memory.
- Holds the CPU in reset while loading; releases it once the checksum passes.
- Feeds the memory write port (address, data, write strobe) and the pc/memory reset path.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); minimum 4.
- BASE_ADDR, 16'h0000, memory address of the first payload byte.
- MAX_LEN, 16'h0800, largest accepted payload length in bytes.
- TIMEOUT_BITS, 40, inter-byte timeout in bit times (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  UART receive line, idle high, asynchronous to clk.
- mem_addr  out  16  write address to program memory.
- mem_wdata  out  8  write data to program memory.
- mem_we  out  1  one-cycle write strobe; mem_addr/mem_wdata valid while high.
- cpu_hold  out  1  1 = hold pc/control unit in reset (drives pc_rst/mem_rst path).
- done  out  1  1 = valid image loaded, CPU running.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous): mem_addr=0, mem_wdata=0, mem_we=0, cpu_hold=1, done=0, err=0, FSM=S_SYNC, rx receiver idle.
- rx input: double-flop synchronised before use.
- Receiver start detect:
  - Falling edge on the synchronised rx starts a frame.
  - Re-sample at CLKS_PER_BIT/2; if high, treat as a false start and return to idle.
- Receiver data and stop:
  - 8 data bits sampled at bit centres, every CLKS_PER_BIT cycles, LSB first.
  - Stop bit sampled at its centre.
  - If stop bit = 1: one-cycle internal byte_valid.
  - If stop bit = 0: framing error; byte discarded, err=1, FSM returns to S_SYNC.
- Receive latency: byte_valid occurs 9.5 bit times after the start-bit falling edge (±2 cycles from synchroniser).
- Frame format: 0xA5, LEN_H, LEN_L, LEN payload bytes, CSUM.
- Frame acceptance: frame is good when (sum of payload + CSUM) mod 256 == 0.
- FSM transitions (each advances on byte_valid only):
  - S_SYNC: bytes other than 0xA5 are ignored. On 0xA5: err cleared, cpu_hold=1, done=0, go to S_LEN_H.
  - S_LEN_H: latch high length byte, go to S_LEN_L.
  - S_LEN_L: latch low length byte. If LEN==0 or LEN>MAX_LEN: err=1, back to S_SYNC. Otherwise clear index and sum, go to S_DATA.
  - S_DATA: on the cycle after byte_valid, mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+index (mod 2^16, wraps 16'hFFFF->16'h0000), mem_wdata=byte. sum += byte (8-bit wrap), index++. After byte LEN, go to S_CSUM.
  - S_CSUM: if (sum+byte) mod 256 == 0, set done=1, cpu_hold=0, go to S_RUN. Otherwise err=1, cpu_hold stays 1, back to S_SYNC.
  - S_RUN: 0xA5 reasserts cpu_hold=1, clears done, goes to S_LEN_H (reload). Other bytes are ignored.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- mem_we is never high outside S_DATA.
- cpu_hold changes only on the cycle following the deciding byte_valid.
- err is sticky: cleared only by reset or by a 0xA5 accepted in S_SYNC/S_RUN.
- Reset mid-frame aborts everything immediately. No further mem_we is issued; memory contents already written are left as-is.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a counter runs in S_LEN_H, S_LEN_L, S_DATA and S_CSUM and clears on every byte_valid. On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: err=1, FSM to S_SYNC, cpu_hold stays 1.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Test Plan:
- Basic load (CLKS_PER_BIT=8, BASE_ADDR=16'h0000). Send A5 00 03 11 22 33 9A -> writes 11@0000, 22@0001, 33@0002, one mem_we cycle each; then done=1, cpu_hold=0, err=0.
- Bad checksum. Send A5 00 02 10 20 00 -> two writes occur; then err=1, done=0, cpu_hold=1, FSM back in S_SYNC.
- Length limits. Send A5 00 00, then A5 08 01 (MAX_LEN=0x0800) -> err=1 each time, no mem_we.
- Address wrap (BASE_ADDR=16'hFFFF). Send A5 00 02 AA 55 01 -> writes AA@FFFF, 55@0000; done=1.
- Framing error mid-payload. Stop bit driven 0 on the second payload byte -> err=1, S_SYNC. A 0.3-bit low glitch on idle rx -> no byte received.
- Reset and reload. Pull rst low during S_DATA -> all outputs at reset values immediately. After a successful load, send A5 -> cpu_hold=1, done=0. With LOADER_TIMEOUT_EN, stall 41 bit times after LEN_L -> err=1.
